// File: rtl/image_loader.sv
// Unpacks received image bytes into a 1-bit-wide pixel RAM, LSB first, then
// launches the classifier and holds off new images until it reports done.
module image_loader #(
    parameter int unsigned NUM_BYTES = 98,
    parameter int unsigned AW        = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_rdy,
    input  logic [7:0]    rx_data,
    input  logic          core_done,
    input  logic          clr_ovf,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic          wdata,
    output logic          start,
    output logic          img_busy,
    output logic          overflow
);

    localparam int unsigned BCW = $clog2(NUM_BYTES + 1);

    typedef enum logic [1:0] {IDLE, UNPACK, LAUNCH, WAIT_CORE} state_e;

    state_e           state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [AW-1:0]    pix_addr_q, pix_addr_d;
    logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
    logic             we_q, we_d;
    logic [AW-1:0]    waddr_q, waddr_d;
    logic             wdata_q, wdata_d;
    logic             start_q, start_d;
    logic             img_busy_q, img_busy_d;
    logic             overflow_q, overflow_d;
    logic             ovf_set;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            bit_cnt_q    <= '0;
            pix_addr_q   <= '0;
            byte_cnt_q   <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= 1'b0;
            start_q      <= 1'b0;
            img_busy_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            bit_cnt_q    <= bit_cnt_d;
            pix_addr_q   <= pix_addr_d;
            byte_cnt_q   <= byte_cnt_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            start_q      <= start_d;
            img_busy_q   <= img_busy_d;
            overflow_q   <= overflow_d;
        end
    end

    // Next-state logic; outputs are registered from the next-state values so
    // they describe the cycle the FSM is entering.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        bit_cnt_d    = bit_cnt_q;
        pix_addr_d   = pix_addr_q;
        byte_cnt_d   = byte_cnt_q;
        ovf_set      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A byte parked in hold as the previous one finished is drained first
                if (hold_valid_q) begin
                    shreg_d      = hold_q;
                    bit_cnt_d    = '0;
                    hold_valid_d = 1'b0;
                    state_d      = UNPACK;
                    if (rx_rdy) begin
                        hold_d       = rx_data;
                        hold_valid_d = 1'b1;
                    end
                end else if (rx_rdy) begin
                    shreg_d   = rx_data;
                    bit_cnt_d = '0;
                    state_d   = UNPACK;
                end
            end
            UNPACK: begin
                shreg_d    = {1'b0, shreg_q[7:1]};
                pix_addr_d = pix_addr_q + AW'(1);
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (rx_rdy) begin
                    if (hold_valid_q) begin
                        ovf_set = 1'b1;
                    end else begin
                        hold_d       = rx_data;
                        hold_valid_d = 1'b1;
                    end
                end
                if (bit_cnt_q == 3'd7) begin
                    byte_cnt_d = byte_cnt_q + BCW'(1);
                    if (byte_cnt_q == BCW'(NUM_BYTES - 1)) begin
                        pix_addr_d = '0;
                        state_d    = LAUNCH;
                    end else if (hold_valid_q) begin
                        shreg_d      = hold_q;
                        hold_valid_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            LAUNCH: begin
                pix_addr_d = '0;
                byte_cnt_d = '0;
                if (hold_valid_q || rx_rdy) begin
                    ovf_set = 1'b1;
                end
                hold_valid_d = 1'b0;
                state_d      = WAIT_CORE;
            end
            WAIT_CORE: begin
                if (rx_rdy) begin
                    ovf_set = 1'b1;
                end
                if (core_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        we_d       = (state_d == UNPACK);
        waddr_d    = pix_addr_d;
        wdata_d    = shreg_d[0];
        start_d    = (state_d == LAUNCH);
        img_busy_d = (state_d == LAUNCH) || (state_d == WAIT_CORE);
        overflow_d = ovf_set ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
    end

    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign start    = start_q;
    assign img_busy = img_busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader: byte unpacking, hold/overflow handling,
// image hand-off, WAIT_CORE behaviour and reset.
module tb_image_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       core_done = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       we;
    logic [9:0] waddr;
    logic       wdata;
    logic       start;
    logic       img_busy;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    image_loader #(.NUM_BYTES(98), .AW(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .core_done (core_done),
        .clr_ovf   (clr_ovf),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .start     (start),
        .img_busy  (img_busy),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        rx_data = d;
        rx_rdy  = 1'b1;
        tick();
        rx_rdy  = 1'b0;
    endtask

    function automatic bit wr_ok(input int addr, input logic bitv);
        return (we === 1'b1) && (waddr === 10'(addr)) && (wdata === bitv);
    endfunction

    // n bytes spaced 20 cycles apart; each write checked against address and data
    task automatic stream(input int n, input int base, output int bad, output int starts);
        logic [7:0] d;
        bad = 0;
        starts = 0;
        for (int b = 0; b < n; b++) begin
            d = 8'(b * 37 + 11);
            send(d);
            for (int i = 0; i < 8; i++) begin
                if (!wr_ok(base + 8 * b + i, d[i])) bad++;
                if (start) starts++;
                tick();
            end
            if (b != n - 1) begin
                for (int g = 0; g < 11; g++) begin
                    if (we || start) bad++;
                    tick();
                end
            end
        end
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] b2;
        logic       exp_bit;
        int         bad;
        int         starts;

        // Reset values and clean release
        #12;
        check("rst_we", 32'(we), 0);
        check("rst_waddr", 32'(waddr), 0);
        check("rst_wdata", 32'(wdata), 0);
        check("rst_start", 32'(start), 0);
        check("rst_busy", 32'(img_busy), 0);
        check("rst_ovf", 32'(overflow), 0);
        #4 rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (we || start) bad++;
        end
        check("rel_no_pulse", 32'(bad), 0);

        // Single byte 0xA5
        a = 8'hA5;
        send(a);
        for (int i = 0; i < 8; i++) begin
            check("a5_we", 32'(we), 1);
            check("a5_waddr", 32'(waddr), 32'(i));
            check("a5_wdata", 32'(wdata), 32'(a[i]));
            tick();
        end
        check("a5_we_after", 32'(we), 0);

        // Two bytes 3 cycles apart: 16 back-to-back writes
        a = 8'h3C;
        b2 = 8'h81;
        bad = 0;
        send(a);
        for (int c = 0; c < 16; c++) begin
            exp_bit = (c < 8) ? a[c] : b2[c - 8];
            if (!wr_ok(8 + c, exp_bit)) bad++;
            if (c == 2) begin rx_data = b2; rx_rdy = 1'b1; end
            if (c == 3) rx_rdy = 1'b0;
            tick();
        end
        check("pair_writes", 32'(bad), 0);
        check("pair_idle", 32'(we), 0);
        check("pair_ovf", 32'(overflow), 0);

        // Third byte while hold is full is dropped
        bad = 0;
        send(8'h00);
        for (int c = 0; c < 16; c++) begin
            if (!wr_ok(24 + c, 1'b0)) bad++;
            if (c == 0) begin rx_data = 8'h00; rx_rdy = 1'b1; end
            if (c == 1) rx_data = 8'hFF;
            if (c == 2) rx_rdy = 1'b0;
            tick();
        end
        check("drop_writes", 32'(bad), 0);
        check("drop_ovf", 32'(overflow), 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_ovf", 32'(overflow), 0);

        // core_done in IDLE ignored
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("idle_done_busy", 32'(img_busy), 0);
        check("idle_done_start", 32'(start), 0);
        check("idle_done_we", 32'(we), 0);

        // Overflow event wins over clr_ovf; core_done ignored while unpacking
        a = 8'h0F;
        b2 = 8'h11;
        bad = 0;
        send(a);
        for (int c = 0; c < 16; c++) begin
            exp_bit = (c < 8) ? a[c] : b2[c - 8];
            if (!wr_ok(40 + c, exp_bit)) bad++;
            if (c == 0) begin rx_data = b2; rx_rdy = 1'b1; end
            if (c == 1) begin rx_data = 8'h22; clr_ovf = 1'b1; core_done = 1'b1; end
            if (c == 2) begin rx_rdy = 1'b0; clr_ovf = 1'b0; core_done = 1'b0; end
            tick();
        end
        check("coinc_writes", 32'(bad), 0);
        check("coinc_ovf", 32'(overflow), 1);

        // Bring the image to 40 bytes, then reset mid-byte
        stream(33, 56, bad, starts);
        check("p40_writes", 32'(bad), 0);
        check("p40_starts", 32'(starts), 0);
        send(8'h5A);
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        check("mid_rst_we", 32'(we), 0);
        check("mid_rst_waddr", 32'(waddr), 0);
        check("mid_rst_wdata", 32'(wdata), 0);
        check("mid_rst_start", 32'(start), 0);
        check("mid_rst_busy", 32'(img_busy), 0);
        check("mid_rst_ovf", 32'(overflow), 0);
        tick();
        #3 rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (we || start) bad++;
        end
        check("mid_rel_no_pulse", 32'(bad), 0);

        // Full 98-byte image from address 0
        stream(98, 0, bad, starts);
        check("img_writes", 32'(bad), 0);
        check("img_no_early_start", 32'(starts), 0);
        check("img_start", 32'(start), 1);
        check("img_start_busy", 32'(img_busy), 1);
        check("img_start_we", 32'(we), 0);
        check("img_ovf", 32'(overflow), 0);
        tick();
        check("img_start_once", 32'(start), 0);
        check("img_wait_busy", 32'(img_busy), 1);

        // rx_rdy during WAIT_CORE is dropped
        send(8'h55);
        bad = 0;
        for (int c = 0; c < 9; c++) begin
            if (we || start) bad++;
            tick();
        end
        check("wait_no_write", 32'(bad), 0);
        check("wait_busy", 32'(img_busy), 1);
        check("wait_ovf", 32'(overflow), 1);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("done_busy", 32'(img_busy), 0);

        // Next image restarts at address 0
        bad = 0;
        send(8'hFF);
        for (int i = 0; i < 8; i++) begin
            if (!wr_ok(i, 1'b1)) bad++;
            tick();
        end
        check("next_img_writes", 32'(bad), 0);
        check("next_img_idle", 32'(we), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 98, meaning bytes per image (784 pixels / 8).
REQ-002 SHALL have parameter AW, default 10, meaning pixel RAM address width.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx_rdy  input  1  one-cycle pulse, rx_data valid.
REQ-006 rx_data  input  8  received byte, pixel 8k+i in bit i (LSB first).
REQ-007 core_done  input  1  classifier finished, one-cycle pulse.
REQ-008 clr_ovf  input  1  clears overflow.
REQ-009 we  output  1  pixel RAM write enable.
REQ-010 waddr  output  AW  pixel RAM write address.
REQ-011 wdata  output  1  pixel bit to write.
REQ-012 start  output  1  one-cycle pulse launching classifier.
REQ-013 img_busy  output  1  image handed off, classifier running.
REQ-014 overflow  output  1  sticky, a byte was dropped.

Function
REQ-015 States SHALL be IDLE, UNPACK, LAUNCH, WAIT_CORE; reset state IDLE.
REQ-016 IDLE: rx_rdy loads rx_data into 8-bit shift register, bit_cnt=0, next UNPACK.
REQ-017 Latency: rx_rdy at cycle N -> first write (we=1) at cycle N+1.
REQ-018 UNPACK: each cycle we=1, wdata=shreg[0], waddr=pix_addr; then shreg shifts right, pix_addr+1, bit_cnt+1.
REQ-019 UNPACK lasts exactly 8 cycles per byte; we=0 in all other states.
REQ-020 After bit 7: byte_cnt+1; if byte_cnt was NUM_BYTES-1 -> LAUNCH; else if hold_valid -> load hold into shreg, clear hold_valid, stay UNPACK (no idle cycle); else -> IDLE.
REQ-021 rx_rdy during UNPACK with hold_valid=0: capture into 1-byte hold register, hold_valid=1.
REQ-022 rx_rdy during UNPACK on the cycle bit 7 is written with hold_valid=0: byte goes to hold, handled per REQ-020 next byte.
REQ-023 rx_rdy during UNPACK with hold_valid=1: byte dropped, overflow set.
REQ-024 LAUNCH: start=1 for exactly one cycle; pix_addr, byte_cnt cleared; hold_valid=1 at entry -> hold discarded, overflow set; next WAIT_CORE.
REQ-025 WAIT_CORE: rx_rdy ignored, sets overflow; core_done -> IDLE next cycle.
REQ-026 core_done outside WAIT_CORE SHALL be ignored.
REQ-027 img_busy=1 in LAUNCH and WAIT_CORE, else 0.
REQ-028 Last write of an image SHALL be waddr=8*NUM_BYTES-1 (783); pix_addr never wraps.
REQ-029 overflow sticky until clr_ovf; simultaneous set and clr_ovf -> overflow=1.
REQ-030 start and we SHALL never be high in the same cycle.

Reset
REQ-031 rst_n low: state IDLE, we=0, waddr=0, wdata=0, start=0, img_busy=0, overflow=0, byte_cnt=0, bit_cnt=0, hold_valid=0.
REQ-032 Reset mid-image discards partial image; next byte after reset writes from waddr=0.
REQ-033 Reset release SHALL not produce start or we pulses.

Verification
REQ-034 Byte 0xA5 rx_rdy at cycle N -> we=1 cycles N+1..N+8, waddr 0..7, wdata 1,0,1,0,0,1,0,1.
REQ-035 98 bytes spaced 20 cycles -> 784 writes, waddr 0..783 once each, single start pulse one cycle after waddr=783, img_busy=1 until core_done.
REQ-036 Two bytes 3 cycles apart -> 16 consecutive writes, no gap, overflow=0; third byte while hold full -> dropped, overflow=1, clr_ovf -> overflow=0.
REQ-037 rx_rdy during WAIT_CORE -> no write, overflow=1; core_done then byte 0xFF -> writes at waddr 0..7 all 1.
REQ-038 rst_n asserted after 40 bytes -> all outputs 0; new 98-byte image -> writes from waddr 0, exactly one start.
REQ-039 core_done in IDLE and clr_ovf coincident with overflow event -> no state change, overflow=1.
